// File: rtl/result_uart_reporter_if.sv
// Valid/ready word channel between the processor core and the result reporter.
interface result_uart_reporter_if;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;

    modport master (output data_in, output data_valid, input  data_ready);
    modport slave  (input  data_in, input  data_valid, output data_ready);
endinterface

// File: rtl/result_uart_reporter.sv
// Converts each accepted 16-bit result to decimal (sequential double-dabble) and
// sends it as an ASCII line "digits CR LF" on an 8N1 UART TX pin.
module result_uart_reporter #(
    parameter int unsigned CLKS_PER_BIT           = 868,
    parameter bit          SUPPRESS_LEADING_ZEROS = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    result_uart_reporter_if.slave        bus,
    output logic                         busy,
    output logic                         uart_tx,
    output logic [19:0]                  bcd_out
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONVERT, S_LOAD_CHAR, S_START, S_DATA, S_STOP
    } state_t;

    state_t      r_state, w_next_state;
    logic [15:0] r_data;
    logic [19:0] r_bcd, r_bcd_out;
    logic [3:0]  r_iter;
    logic [15:0] r_baud;
    logic [2:0]  r_bit, r_idx, w_first_idx;
    logic [7:0]  r_char;
    logic        r_tx, r_ready, r_busy;
    logic [19:0] w_adj, w_bcd_next;
    logic        w_bit_done, w_accept, w_last_char;

    // Character index 0..4 = ten-thousands..units digit, 5 = CR, 6 = LF.
    function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [19:0] bcd);
        case (idx)
            3'd0:    return {4'h3, bcd[19:16]};
            3'd1:    return {4'h3, bcd[15:12]};
            3'd2:    return {4'h3, bcd[11:8]};
            3'd3:    return {4'h3, bcd[7:4]};
            3'd4:    return {4'h3, bcd[3:0]};
            3'd5:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign w_bit_done  = (r_baud == BAUD_LAST);
    assign w_accept    = bus.data_valid && r_ready;
    assign w_last_char = (r_idx == 3'd6);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_bcd_next = {w_adj[18:0], r_data[15]};
    end

    always_comb begin
        w_first_idx = 3'd0;
        if (SUPPRESS_LEADING_ZEROS) begin
            if      (r_bcd_out[19:16] != 4'd0) w_first_idx = 3'd0;
            else if (r_bcd_out[15:12] != 4'd0) w_first_idx = 3'd1;
            else if (r_bcd_out[11:8]  != 4'd0) w_first_idx = 3'd2;
            else if (r_bcd_out[7:4]   != 4'd0) w_first_idx = 3'd3;
            else                               w_first_idx = 3'd4;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next_state = S_CONVERT;
            S_CONVERT:   if (r_iter == 4'd15) w_next_state = S_LOAD_CHAR;
            S_LOAD_CHAR: w_next_state = S_START;
            S_START:     if (w_bit_done) w_next_state = S_DATA;
            S_DATA:      if (w_bit_done && r_bit == 3'd7) w_next_state = S_STOP;
            S_STOP:      if (w_bit_done) w_next_state = w_last_char ? S_IDLE : S_START;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_bcd     <= '0;
            r_bcd_out <= '0;
            r_iter    <= '0;
            r_baud    <= '0;
            r_bit     <= '0;
            r_idx     <= '0;
            r_char    <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == S_IDLE);
            r_busy  <= (w_next_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data <= bus.data_in;
                        r_bcd  <= '0;
                        r_iter <= '0;
                    end
                end
                S_CONVERT: begin
                    r_bcd  <= w_bcd_next;
                    r_data <= {r_data[14:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == 4'd15) r_bcd_out <= w_bcd_next;
                end
                S_LOAD_CHAR: begin
                    r_idx  <= w_first_idx;
                    r_char <= char_at(w_first_idx, r_bcd_out);
                    r_baud <= '0;
                    r_tx   <= 1'b0;
                end
                S_START: begin
                    if (!w_bit_done) r_baud <= r_baud + 16'd1;
                    else begin
                        r_baud <= '0;
                        r_bit  <= '0;
                        r_tx   <= r_char[0];
                        r_char <= {1'b0, r_char[7:1]};
                    end
                end
                S_DATA: begin
                    if (!w_bit_done) r_baud <= r_baud + 16'd1;
                    else begin
                        r_baud <= '0;
                        r_bit  <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_tx <= 1'b1;
                        else begin
                            r_tx   <= r_char[0];
                            r_char <= {1'b0, r_char[7:1]};
                        end
                    end
                end
                S_STOP: begin
                    if (!w_bit_done) r_baud <= r_baud + 16'd1;
                    else begin
                        r_baud <= '0;
                        // Next start bit follows the stop bit with no idle gap.
                        if (!w_last_char) begin
                            r_idx  <= r_idx + 3'd1;
                            r_char <= char_at(r_idx + 3'd1, r_bcd_out);
                            r_tx   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_ready = r_ready;
    assign busy           = r_busy;
    assign uart_tx        = r_tx;
    assign bcd_out        = r_bcd_out;
endmodule

// File: tb/tb_result_uart_reporter.sv
// Directed bench: two reporters (leading-zero suppression on/off) at 4 clocks per bit.
module tb_result_uart_reporter;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        data_valid;
    logic        busy1, busy0, tx1, tx0;
    logic [19:0] bcd1, bcd0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  rx1[$];
    logic [7:0]  rx0[$];

    result_uart_reporter_if bus1();
    result_uart_reporter_if bus0();
    assign bus1.data_in    = data_in;
    assign bus1.data_valid = data_valid;
    assign bus0.data_in    = data_in;
    assign bus0.data_valid = data_valid;

    result_uart_reporter #(.CLKS_PER_BIT(4), .SUPPRESS_LEADING_ZEROS(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .busy(busy1), .uart_tx(tx1), .bcd_out(bcd1)
    );
    result_uart_reporter #(.CLKS_PER_BIT(4), .SUPPRESS_LEADING_ZEROS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .busy(busy0), .uart_tx(tx0), .bcd_out(bcd0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic get_tx(input int which);
        return (which == 1) ? tx1 : tx0;
    endfunction

    function automatic logic get_ready(input int which);
        return (which == 1) ? bus1.data_ready : bus0.data_ready;
    endfunction

    function automatic string crlf(input string d);
        return $sformatf("%s%c%c", d, 8'd13, 8'd10);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Samples one frame from its first start-bit cycle; every bit must hold for 4 samples.
    task automatic rx_frame(input int which, output logic [7:0] b, output bit aborted, output bit good);
        logic [9:0] bits;
        bit         stable;
        logic       v;
        bits    = '0;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step();
            if (!reset) begin
                aborted = 1'b1;
                b       = 8'h00;
                good    = 1'b0;
                return;
            end
            v = get_tx(which);
            if (k % 4 == 0) bits[k/4] = v;
            else if (v !== bits[k/4]) stable = 1'b0;
        end
        good = stable && (bits[0] == 1'b0) && (bits[9] == 1'b1);
        b    = bits[8:1];
    endtask

    task automatic monitor(input int which);
        logic [7:0] b;
        bit         ab, good;
        forever begin
            step();
            if (reset === 1'b1 && get_tx(which) === 1'b0) begin
                rx_frame(which, b, ab, good);
                if (!ab) begin
                    check($sformatf("frame%0d format", which), 32'(good), 32'd1);
                    if (which == 1) rx1.push_back(b);
                    else            rx0.push_back(b);
                end
            end
        end
    endtask

    initial monitor(1);
    initial monitor(0);

    task automatic check_line(input string tag, input int which, input string exp);
        int n;
        n = (which == 1) ? rx1.size() : rx0.size();
        check({tag, " len"}, n, exp.len());
        for (int i = 0; i < exp.len() && i < n; i++)
            check($sformatf("%s[%0d]", tag, i), (which == 1) ? rx1[i] : rx0[i], 32'(exp[i]));
    endtask

    task automatic wait_ready(input int which, input int limit, output int e);
        int n = 0;
        while (get_ready(which) !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check($sformatf("ready%0d timeout", which), 32'(get_ready(which)), 32'd1);
        e = cyc;
    endtask

    task automatic send(input logic [15:0] v, output int t);
        @(negedge clk);
        data_in    = v;
        data_valid = 1'b1;
        step();
        t          = cyc;
        data_valid = 1'b0;
    endtask

    task automatic idle_both();
        int e;
        wait_ready(1, 1000, e);
        wait_ready(0, 1000, e);
        repeat (2) step();
        rx1.delete();
        rx0.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, e;
        reset      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        repeat (3) step();
        check("rst tx",    32'(tx1), 32'd1);
        check("rst ready", 32'(bus1.data_ready), 32'd1);
        check("rst busy",  32'(busy1), 32'd0);
        check("rst bcd",   32'(bcd1), 32'h0);
        check("rst tx0",   32'(tx0), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) step();

        // 1234: latency, BCD timing, line contents and return to ready
        check("pre ready", 32'(bus1.data_ready), 32'd1);
        send(16'd1234, t);
        check("1234 ready low", 32'(bus1.data_ready), 32'd0);
        check("1234 busy",      32'(busy1), 32'd1);
        repeat (15) step();
        check("1234 bcd early", 32'(bcd1), 32'h0);
        step();
        check("1234 bcd",       32'(bcd1), 32'h01234);
        check("1234 tx idle",   32'(tx1), 32'd1);
        step();
        check("1234 start bit", 32'(tx1), 32'd0);
        wait_ready(1, 400, e);
        check("1234 ready at", e - t, 257);
        check_line("line 1234", 1, crlf("1234"));
        wait_ready(0, 400, e);
        check_line("line0 01234", 0, crlf("01234"));
        idle_both();

        // zero still sends one digit
        send(16'd0, t);
        repeat (16) step();
        check("0 bcd", 32'(bcd1), 32'h0);
        wait_ready(1, 400, e);
        check("0 ready at", e - t, 137);
        check_line("line 0", 1, crlf("0"));
        idle_both();

        // maximum value
        send(16'd65535, t);
        repeat (16) step();
        check("65535 bcd", 32'(bcd1), 32'h65535);
        repeat (280) step();
        check("65535 busy end-1", 32'(busy1), 32'd1);
        step();
        check("65535 busy end",  32'(busy1), 32'd0);
        check("65535 ready end", 32'(bus1.data_ready), 32'd1);
        check_line("line 65535", 1, crlf("65535"));
        idle_both();

        // 42 with and without leading-zero suppression
        send(16'd42, t);
        wait_ready(0, 400, e);
        check("42 bcd0", 32'(bcd0), 32'h00042);
        check_line("line0 00042", 0, crlf("00042"));
        check_line("line 42", 1, crlf("42"));
        idle_both();

        // valid held through the first line; 9 accepted on first ready edge
        @(negedge clk);
        data_in    = 16'd7;
        data_valid = 1'b1;
        step();
        t = cyc;
        data_in = 16'd9;
        wait_ready(1, 400, e);
        check("hold ready at", e - t, 137);
        step();
        check("hold accepted", 32'(bus1.data_ready), 32'd0);
        data_valid = 1'b0;
        wait_ready(1, 400, e);
        check("hold bcd", 32'(bcd1), 32'h00009);
        check_line("line 7 9", 1, {crlf("7"), crlf("9")});
        idle_both();

        // reset during the data bits of the second character
        send(16'd1234, t);
        repeat (69) step();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("abort tx",    32'(tx1), 32'd1);
        check("abort busy",  32'(busy1), 32'd0);
        check("abort bcd",   32'(bcd1), 32'h0);
        check("abort ready", 32'(bus1.data_ready), 32'd1);
        reset = 1'b1;
        check("abort chars", rx1.size(), 1);
        if (rx1.size() > 0) check("abort char0", 32'(rx1[0]), 32'h31);
        idle_both();
        send(16'd5, t);
        wait_ready(1, 400, e);
        check("5 bcd", 32'(bcd1), 32'h00005);
        check_line("line 5", 1, crlf("5"));
        idle_both();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
